// File: rtl/riscv_pkg.sv
// Shared RV64 constants and the writeback buffer entry type.
// Used by the writeback stage and its load-extension helper.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_D  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] LD_WU = 3'b110;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Load alignment and sign/zero extension for RV64 loads out of an 8-byte dword.
// Flags misaligned accesses and the reserved funct3=111 encoding as faults.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    data  = '0;
    fault = 1'b0;
    unique case (funct3)
      LD_B:  data = {{56{shifted[7]}}, shifted[7:0]};
      LD_BU: data = {56'd0, shifted[7:0]};
      LD_H: begin
        data  = {{48{shifted[15]}}, shifted[15:0]};
        fault = addr_lo[0];
      end
      LD_HU: begin
        data  = {48'd0, shifted[15:0]};
        fault = addr_lo[0];
      end
      LD_W: begin
        data  = {{32{shifted[31]}}, shifted[31:0]};
        fault = (addr_lo[1:0] != 2'b00);
      end
      LD_WU: begin
        data  = {32'd0, shifted[31:0]};
        fault = (addr_lo[1:0] != 2'b00);
      end
      LD_D: begin
        data  = rdata;
        fault = (addr_lo != 3'b000);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: selects ALU or load result, buffers up to two pending register writes
// behind a shared write port, and offers youngest-first forwarding to EX.
module writeback_stage
  import riscv_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_mem_rdata,
  input  logic [2:0]            in_funct3,
  input  logic                  wb_grant,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [XLEN-1:0]       WriteData,
  output logic                  RegWrite,
  output logic                  load_fault,
  input  logic [REG_ADDR_W-1:0] fwd_query_rd,
  output logic                  fwd_hit,
  output logic [XLEN-1:0]       fwd_data
);

  wb_entry_t             head_q, head_d;
  wb_entry_t             skid_q, skid_d;
  logic [REG_ADDR_W-1:0] last_rd_q, last_rd_d;
  logic [XLEN-1:0]       last_data_q, last_data_d;
  logic                  load_fault_q, load_fault_d;

  logic [XLEN-1:0] ext_data;
  logic            ext_fault;
  logic            fault;
  logic            accept;
  logic            retire;
  wb_entry_t       new_entry;
  wb_entry_t       head_after;
  wb_entry_t       skid_after;

  load_extend u_load_extend (
    .rdata   (in_mem_rdata),
    .addr_lo (in_alu_result[2:0]),
    .funct3  (in_funct3),
    .data    (ext_data),
    .fault   (ext_fault)
  );

  assign in_ready = !skid_q.valid;
  assign accept   = in_valid && in_ready;
  assign fault    = in_mem_to_reg && ext_fault;
  // Entries that never write (rd=x0, faulted) retire without waiting for the port.
  assign retire   = head_q.valid && ((head_q.we && wb_grant) || !head_q.we);

  always_comb begin
    new_entry.valid = 1'b1;
    new_entry.we    = in_reg_write && (in_rd != '0) && !fault;
    new_entry.rd    = in_rd;
    new_entry.data  = in_mem_to_reg ? ext_data : in_alu_result;
  end

  always_comb begin
    head_after   = retire ? skid_q : head_q;
    skid_after   = retire ? wb_entry_t'('0) : skid_q;
    head_d       = head_after;
    skid_d       = skid_after;
    load_fault_d = accept && fault;
    if (accept) begin
      if (!head_after.valid) begin
        head_d = new_entry;
      end else begin
        skid_d = new_entry;
      end
    end
    last_rd_d   = head_q.valid ? head_q.rd   : last_rd_q;
    last_data_d = head_q.valid ? head_q.data : last_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      skid_q       <= '0;
      last_rd_q    <= '0;
      last_data_q  <= '0;
      load_fault_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      last_rd_q    <= last_rd_d;
      last_data_q  <= last_data_d;
      load_fault_q <= load_fault_d;
    end
  end

  assign RegWrite   = head_q.valid && head_q.we && wb_grant;
  assign WriteReg   = head_q.valid ? head_q.rd   : last_rd_q;
  assign WriteData  = head_q.valid ? head_q.data : last_data_q;
  assign load_fault = load_fault_q;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_query_rd != '0) begin
      if (skid_q.valid && skid_q.we && (skid_q.rd == fwd_query_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_q.data;
      end else if (head_q.valid && head_q.we && (head_q.rd == fwd_query_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = head_q.data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;
  import riscv_pkg::*;

  logic                  clock;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_write;
  logic                  in_mem_to_reg;
  logic [XLEN-1:0]       in_alu_result;
  logic [XLEN-1:0]       in_mem_rdata;
  logic [2:0]            in_funct3;
  logic                  wb_grant;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [XLEN-1:0]       WriteData;
  logic                  RegWrite;
  logic                  load_fault;
  logic [REG_ADDR_W-1:0] fwd_query_rd;
  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [XLEN-1:0] RDATA = 64'h8877_6655_4433_2211;

  writeback_stage dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_alu_result (in_alu_result),
    .in_mem_rdata  (in_mem_rdata),
    .in_funct3     (in_funct3),
    .wb_grant      (wb_grant),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .load_fault    (load_fault),
    .fwd_query_rd  (fwd_query_rd),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic m2r, input logic [63:0] alu,
                       input logic [2:0] f3);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_reg_write  = 1'b1;
    in_mem_to_reg = m2r;
    in_alu_result = alu;
    in_mem_rdata  = RDATA;
    in_funct3     = f3;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Issue one load with the port granted and check the write it produces.
  task automatic load_case(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                           input logic [63:0] exp);
    drive(5'd10, 1'b1, addr, f3);
    tick();
    idle();
    check({tag, "_regwrite"}, 64'(RegWrite), 64'd1);
    check({tag, "_data"}, WriteData, exp);
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_rd         = '0;
    in_reg_write  = 1'b0;
    in_mem_to_reg = 1'b0;
    in_alu_result = '0;
    in_mem_rdata  = '0;
    in_funct3     = '0;
    wb_grant      = 1'b1;
    fwd_query_rd  = 5'd3;
    tick();
    tick();
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_writereg", 64'(WriteReg), 64'd0);
    check("rst_writedata", WriteData, 64'd0);
    check("rst_load_fault", 64'(load_fault), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    reset = 1'b0;
    tick();

    // ALU write
    drive(5'd5, 1'b0, 64'h1234, LD_D);
    tick();
    idle();
    check("alu_regwrite", 64'(RegWrite), 64'd1);
    check("alu_writereg", 64'(WriteReg), 64'd5);
    check("alu_writedata", WriteData, 64'h1234);
    tick();
    check("alu_regwrite_drop", 64'(RegWrite), 64'd0);
    check("alu_writereg_hold", 64'(WriteReg), 64'd5);

    // Loads
    load_case("lb3", 64'h1003, LD_B, 64'h44);
    load_case("lh6", 64'h1006, LD_H, 64'hFFFF_FFFF_FFFF_8877);
    load_case("lwu4", 64'h1004, LD_WU, 64'h8877_6655);
    load_case("ld0", 64'h1000, LD_D, RDATA);
    load_case("lbu7", 64'h1007, LD_BU, 64'h88);
    load_case("lw0", 64'h1000, LD_W, 64'h4433_2211);

    // Misaligned lw
    drive(5'd7, 1'b1, 64'h1002, LD_W);
    tick();
    idle();
    check("mis_fault", 64'(load_fault), 64'd1);
    check("mis_regwrite", 64'(RegWrite), 64'd0);
    check("mis_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("mis_fault_pulse", 64'(load_fault), 64'd0);
    check("mis_regwrite2", 64'(RegWrite), 64'd0);
    check("mis_in_ready2", 64'(in_ready), 64'd1);

    // Back-pressure
    wb_grant = 1'b0;
    drive(5'd1, 1'b0, 64'h11, LD_D);
    tick();
    check("bp_ready1", 64'(in_ready), 64'd1);
    drive(5'd2, 1'b0, 64'h22, LD_D);
    tick();
    check("bp_ready2", 64'(in_ready), 64'd0);
    drive(5'd3, 1'b0, 64'h33, LD_D);
    tick();
    check("bp_stall_ready", 64'(in_ready), 64'd0);
    check("bp_stall_regwrite", 64'(RegWrite), 64'd0);
    wb_grant = 1'b1;
    #1;
    check("bp_x1_regwrite", 64'(RegWrite), 64'd1);
    check("bp_x1_reg", 64'(WriteReg), 64'd1);
    check("bp_x1_data", WriteData, 64'h11);
    tick();
    check("bp_x2_reg", 64'(WriteReg), 64'd2);
    check("bp_x2_data", WriteData, 64'h22);
    check("bp_x2_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    check("bp_x3_regwrite", 64'(RegWrite), 64'd1);
    check("bp_x3_reg", 64'(WriteReg), 64'd3);
    check("bp_x3_data", WriteData, 64'h33);
    tick();
    check("bp_drained", 64'(RegWrite), 64'd0);

    // Forwarding
    wb_grant = 1'b0;
    drive(5'd4, 1'b0, 64'hA, LD_D);
    tick();
    fwd_query_rd = 5'd4;
    #1;
    check("fwd_head_hit", 64'(fwd_hit), 64'd1);
    check("fwd_head_data", fwd_data, 64'hA);
    drive(5'd4, 1'b0, 64'hB, LD_D);
    tick();
    idle();
    check("fwd_young_hit", 64'(fwd_hit), 64'd1);
    check("fwd_young_data", fwd_data, 64'hB);
    fwd_query_rd = 5'd6;
    #1;
    check("fwd_miss", 64'(fwd_hit), 64'd0);
    wb_grant = 1'b1;
    tick();
    fwd_query_rd = 5'd4;
    #1;
    check("fwd_after_retire", fwd_data, 64'hB);
    tick();
    check("fwd_drained", 64'(fwd_hit), 64'd0);
    wb_grant = 1'b0;
    drive(5'd0, 1'b0, 64'h99, LD_D);
    fwd_query_rd = 5'd0;
    tick();
    idle();
    check("x0_fwd_hit", 64'(fwd_hit), 64'd0);
    check("x0_fwd_data", fwd_data, 64'd0);
    check("x0_regwrite", 64'(RegWrite), 64'd0);
    tick();
    drive(5'd9, 1'b0, 64'h5A, LD_D);
    tick();
    idle();
    check("x0_retired_ready", 64'(in_ready), 64'd1);
    check("x0_next_reg", 64'(WriteReg), 64'd9);
    wb_grant = 1'b1;
    tick();

    // Reset mid-stall
    wb_grant = 1'b0;
    drive(5'd8, 1'b0, 64'h88, LD_D);
    tick();
    drive(5'd9, 1'b0, 64'h99, LD_D);
    tick();
    idle();
    check("rst_full_ready", 64'(in_ready), 64'd0);
    wb_grant = 1'b1;
    #1;
    check("rst_pre_regwrite", 64'(RegWrite), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_async_regwrite", 64'(RegWrite), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b0;
    fwd_query_rd = 5'd8;
    tick();
    check("rst_post_regwrite", 64'(RegWrite), 64'd0);
    check("rst_post_fwd", 64'(fwd_hit), 64'd0);
    tick();
    check("rst_post_regwrite2", 64'(RegWrite), 64'd0);
    check("rst_post_writereg", 64'(WriteReg), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
